// File: rtl/debias_pkg.sv
// Shared definitions for the pair-debiasing entropy word generator:
// mode/phase encodings and the pair reduction rule.
package debias_pkg;

  localparam logic MODE_XOR = 1'b0;
  localparam logic MODE_VN  = 1'b1;

  typedef enum logic {
    PHASE_FIRST  = 1'b0,
    PHASE_SECOND = 1'b1
  } phase_e;

  typedef struct packed {
    logic valid;
    logic value;
  } pair_res_t;

  // XOR mode always yields ~(a^b); von Neumann yields a only for unequal pairs.
  function automatic pair_res_t pair_eval(input logic mode_i, input logic a_i,
                                          input logic b_i);
    pair_res_t res;
    if (mode_i == MODE_XOR) begin
      res.valid = 1'b1;
      res.value = ~(a_i ^ b_i);
    end else begin
      res.valid = (a_i != b_i);
      res.value = a_i;
    end
    return res;
  endfunction

endpackage

// File: rtl/debias_pair_extractor.sv
// Pairs consecutive raw samples and emits at most one debiased bit per pair.
// The bit is presented combinationally on the edge that samples the second half.
module debias_pair_extractor
  import debias_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic metastable_i,
  input  logic mode_i,
  input  logic flush_i,
  output logic bit_valid_o,
  output logic bit_o
);

  phase_e    phase_q, phase_d;
  logic      a_q, a_d;
  pair_res_t res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PHASE_FIRST;
    end else begin
      phase_q <= phase_d;
    end
  end

  // First-half sample is pure data and needs no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
  end

  always_comb begin
    phase_d     = phase_q;
    a_d         = a_q;
    bit_valid_o = 1'b0;
    bit_o       = 1'b0;
    res         = pair_eval(mode_i, a_q, metastable_i);
    if (flush_i) begin
      phase_d = PHASE_FIRST;
    end else begin
      case (phase_q)
        PHASE_FIRST: begin
          a_d     = metastable_i;
          phase_d = PHASE_SECOND;
        end
        PHASE_SECOND: begin
          phase_d     = PHASE_FIRST;
          bit_valid_o = res.valid;
          bit_o       = res.value;
        end
        default: phase_d = PHASE_FIRST;
      endcase
    end
  end

endmodule

// File: rtl/binary_debias_word.sv
// Debiased random word source: pair extraction, WIDTH-bit assembly, one-word
// output register with valid/ready handshake and sticky overrun flag.
module binary_debias_word
  import debias_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             metastable,
  input  logic             mode,
  input  logic             word_ready,
  output logic             word_valid,
  output logic [WIDTH-1:0] word,
  input  logic             clear_overrun,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic             mode_q, mode_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;

  logic             flush;
  logic             bit_valid;
  logic             bit_val;
  logic             slot_free;
  logic             drop;
  logic [WIDTH-1:0] shift_next;

  // A mode change restarts pairing and discards that edge's sample.
  assign flush = (mode != mode_q);

  debias_pair_extractor u_pair (
    .clk         (clk),
    .rst         (rst),
    .metastable_i(metastable),
    .mode_i      (mode_q),
    .flush_i     (flush),
    .bit_valid_o (bit_valid),
    .bit_o       (bit_val)
  );

  assign slot_free  = !word_valid_q || word_ready;
  assign shift_next = {shift_q[WIDTH-2:0], bit_val};

  always_comb begin
    mode_d       = mode;
    count_d      = count_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    drop         = 1'b0;

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    if (count_q == CNT_FULL) begin
      // Completed word parked in the assembler; it survives a mode change.
      if (slot_free) begin
        word_d       = shift_q;
        word_valid_d = 1'b1;
        count_d      = '0;
        if (bit_valid) begin
          shift_d = {{(WIDTH-1){1'b0}}, bit_val};
          count_d = CW'(1);
        end
      end else if (bit_valid) begin
        drop = 1'b1;
      end
    end else if (flush) begin
      count_d = '0;
      shift_d = '0;
    end else if (bit_valid) begin
      if ((count_q == CNT_LAST) && slot_free) begin
        word_d       = shift_next;
        word_valid_d = 1'b1;
        count_d      = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
      shift_d = shift_next;
    end

    // Set wins over clear on the same edge.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_XOR;
      count_q      <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_binary_debias_word.sv
// Scoreboard bench for binary_debias_word at WIDTH=4.
module tb_binary_debias_word;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         metastable;
  logic         mode;
  logic         word_ready;
  logic         word_valid;
  logic [W-1:0] word;
  logic         clear_overrun;
  logic         overrun;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] expq[$];

  binary_debias_word #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .metastable   (metastable),
    .mode         (mode),
    .word_ready   (word_ready),
    .word_valid   (word_valid),
    .word         (word),
    .clear_overrun(clear_overrun),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one sample; a word handed over on this edge is scored first.
  task automatic step(input logic s);
    logic [W-1:0] e;
    metastable = s;
    if (word_valid && word_ready) begin
      chk("sb_avail", (expq.size() > 0), 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("sb_word", word, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input logic [63:0] pat, input int n);
    for (int i = 0; i < n; i++) step(pat[n-1-i]);
  endtask

  initial begin
    rst = 1'b1; metastable = 1'b0; mode = 1'b0; word_ready = 1'b1;
    clear_overrun = 1'b0;
    #12;
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word, 0);
    chk("rst_ovr", overrun, 0);
    #10 rst = 1'b0;

    // Test 1: von Neumann, 11/00 pairs produce nothing
    mode = 1'b1;
    step(1'b1);
    expq.push_back(4'b1010);
    stream(64'b10011100100, 11);
    chk("t1_early", word_valid, 0);
    step(1'b1);
    chk("t1_valid", word_valid, 1);
    chk("t1_word", word, 4'b1010);

    // Test 2: XOR pairs, back-to-back words
    mode = 1'b0;
    step(1'b0);
    expq.push_back(4'b1010);
    expq.push_back(4'b1010);
    stream(64'b00011110, 8);
    chk("t2_w1_valid", word_valid, 1);
    stream(64'b0001111, 7);
    chk("t2_gap", word_valid, 0);
    step(1'b0);
    chk("t2_w2_valid", word_valid, 1);
    chk("t2_w2_word", word, 4'b1010);

    // Test 3: backpressure in von Neumann mode
    mode = 1'b1;
    step(1'b1);
    word_ready = 1'b0;
    expq.push_back(4'b1111);
    expq.push_back(4'b1111);
    stream(64'b10101010, 8);
    chk("t3_w1_valid", word_valid, 1);
    chk("t3_w1_word", word, 4'b1111);
    stream(64'b10101010, 8);
    chk("t3_hold_valid", word_valid, 1);
    chk("t3_hold_word", word, 4'b1111);
    chk("t3_no_ovr", overrun, 0);
    step(1'b1);
    chk("t3_first_half", overrun, 0);
    step(1'b0);
    chk("t3_drop", overrun, 1);
    word_ready = 1'b1;
    step(1'b1);
    word_ready = 1'b0;
    chk("t3_w2_valid", word_valid, 1);
    chk("t3_w2_word", word, 4'b1111);
    chk("t3_ovr_sticky", overrun, 1);

    // Test 4: toggle with three bits (1,0,0) assembled
    word_ready = 1'b1;
    step(1'b0);
    stream(64'b0101, 4);
    chk("t4_partial", word_valid, 0);
    mode = 1'b0;
    step(1'b1);
    expq.push_back(4'b1111);
    stream(64'b0, 7);
    chk("t4_early", word_valid, 0);
    step(1'b0);
    chk("t4_valid", word_valid, 1);
    chk("t4_word", word, 4'b1111);

    // Test 5: clear versus drop on the same edge
    clear_overrun = 1'b1;
    step(1'b0);
    clear_overrun = 1'b0;
    chk("t5_cleared", overrun, 0);
    word_ready = 1'b0;
    expq.push_back(4'b1111);
    expq.push_back(4'b1111);
    stream(64'b0, 16);
    chk("t5_pre_drop", overrun, 0);
    clear_overrun = 1'b1;
    step(1'b0);
    clear_overrun = 1'b0;
    chk("t5_set_wins", overrun, 1);
    clear_overrun = 1'b1;
    step(1'b0);
    clear_overrun = 1'b0;
    chk("t5_idle_clear", overrun, 0);

    // Test 6: async reset mid-word and mid-pair
    word_ready = 1'b1;
    step(1'b0);
    word_ready = 1'b0;
    step(1'b0);
    chk("t6_pre_valid", word_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", word_valid, 0);
    chk("t6_rst_word", word, 0);
    chk("t6_rst_ovr", overrun, 0);
    #3 rst = 1'b0;
    expq.delete();
    word_ready = 1'b1;
    expq.push_back(4'b1010);
    stream(64'b0001111, 7);
    chk("t6_early", word_valid, 0);
    step(1'b0);
    chk("t6_valid", word_valid, 1);
    chk("t6_word", word, 4'b1010);
    step(1'b0);
    chk("sb_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
